// File: rtl/tone_pkg.sv
// Shared definitions for the tone generator: tone selection, timing constants,
// the quarter-wave sine table and the phase step per tone.
package tone_pkg;

  typedef enum logic [1:0] {
    TONE_1K   = 2'd0,
    TONE_3K   = 2'd1,
    TONE_16K  = 2'd2,
    TONE_MUTE = 2'd3
  } tone_e;

  localparam int CLKS_PER_SAMPLE   = 3;
  localparam int SAMPLES_PER_CYCLE = 48;

  // First quarter of a full-scale sine, sampled at 48 points per period.
  function automatic logic signed [15:0] quarter_wave(input logic [3:0] idx);
    logic signed [15:0] val;
    case (idx)
      4'd0:    val = 16'sd0;
      4'd1:    val = 16'sd4277;
      4'd2:    val = 16'sd8481;
      4'd3:    val = 16'sd12539;
      4'd4:    val = 16'sd16384;
      4'd5:    val = 16'sd19947;
      4'd6:    val = 16'sd23170;
      4'd7:    val = 16'sd25996;
      4'd8:    val = 16'sd28377;
      4'd9:    val = 16'sd30273;
      4'd10:   val = 16'sd31650;
      4'd11:   val = 16'sd32487;
      4'd12:   val = 16'sd32767;
      default: val = 16'sd0;
    endcase
    return val;
  endfunction

  function automatic logic [5:0] tone_step(input tone_e t);
    logic [5:0] s;
    case (t)
      TONE_1K:  s = 6'd1;
      TONE_3K:  s = 6'd3;
      TONE_16K: s = 6'd16;
      default:  s = 6'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sine_lut.sv
// Combinational full-period sine: maps a phase index 0..47 to a signed sample
// by mirroring and negating the quarter-wave table.
module sine_lut
  import tone_pkg::*;
(
  input  logic        [5:0]  phase_i,
  output logic signed [15:0] sample_o
);

  // 12-r within a quadrant reduces to (quadrant end - k), avoiding a divider.
  always_comb begin
    sample_o = 16'sd0;
    if (phase_i < 6'd12) begin
      sample_o = quarter_wave(phase_i[3:0]);
    end else if (phase_i < 6'd24) begin
      sample_o = quarter_wave(4'(6'd24 - phase_i));
    end else if (phase_i < 6'd36) begin
      sample_o = -quarter_wave(4'(phase_i - 6'd24));
    end else if (phase_i < 6'd48) begin
      sample_o = -quarter_wave(4'(6'd48 - phase_i));
    end
  end

endmodule

// File: rtl/tone_gen.sv
// Test-tone source: a sample-rate divider, a phase accumulator stepping through
// a 48-point sine, and registered attenuated output with a one-cycle strobe.
module tone_gen #(
  parameter int CLKS_PER_SAMPLE   = tone_pkg::CLKS_PER_SAMPLE,
  parameter int SAMPLES_PER_CYCLE = tone_pkg::SAMPLES_PER_CYCLE
) (
  input  logic               clk_144,
  input  logic               reset,
  input  logic               enable,
  input  logic        [1:0]  tone,
  input  logic        [2:0]  atten,
  output logic               sample_valid,
  output logic signed [15:0] toneOut
);
  import tone_pkg::*;

  localparam int DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_SAMPLE - 1);
  localparam logic [6:0]       PH_WRAP  = 7'(SAMPLES_PER_CYCLE);

  logic        [DIV_W-1:0] div_q, div_d;
  logic        [5:0]       phase_q, phase_d;
  logic signed [15:0]      tone_out_q, tone_out_d;
  logic                    valid_q, valid_d;

  logic signed [15:0] sine_s;
  logic        [6:0]  phase_sum;
  logic        [5:0]  step;
  tone_e              tone_sel;
  logic               strobe;

  sine_lut u_sine_lut (
    .phase_i  (phase_q),
    .sample_o (sine_s)
  );

  // sample_valid is a bare strobe with no ready: the consumer must take
  // toneOut in the cycle sample_valid is high; toneOut holds until the next one.
  always_comb begin
    tone_sel   = tone_e'(tone);
    step       = tone_step(tone_sel);
    phase_sum  = {1'b0, phase_q} + {1'b0, step};
    strobe     = enable && (div_q == DIV_LAST);
    div_d      = div_q;
    phase_d    = phase_q;
    tone_out_d = tone_out_q;
    valid_d    = 1'b0;
    if (enable) begin
      div_d = strobe ? '0 : div_q + DIV_W'(1);
    end
    if (strobe) begin
      valid_d    = 1'b1;
      tone_out_d = (tone_sel == TONE_MUTE) ? 16'sd0 : (sine_s >>> atten);
      phase_d    = (phase_sum >= PH_WRAP) ? 6'(phase_sum - PH_WRAP) : phase_sum[5:0];
    end
  end

  always_ff @(posedge clk_144) begin
    if (reset) begin
      div_q      <= '0;
      phase_q    <= '0;
      tone_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      div_q      <= div_d;
      phase_q    <= phase_d;
      tone_out_q <= tone_out_d;
      valid_q    <= valid_d;
    end
  end

  assign sample_valid = valid_q;
  assign toneOut      = tone_out_q;

endmodule

// File: tb/tb_tone_gen.sv
// Directed bench for tone_gen: a per-sample vector table of hand-computed
// outputs, then enable-freeze, mid-sample reset and 16 kHz -> 1 kHz sequences.
module tb_tone_gen;

  logic               clk_144 = 1'b0;
  logic               reset;
  logic               enable;
  logic        [1:0]  tone;
  logic        [2:0]  atten;
  logic               sample_valid;
  logic signed [15:0] toneOut;

  int total = 0;
  int bad   = 0;
  logic signed [15:0] exp_q[$];
  logic signed [15:0] held;

  typedef struct {
    logic        [1:0]  tone;
    logic        [2:0]  atten;
    logic signed [15:0] exp_out;
  } vec_t;

  localparam int NVEC = 25;
  vec_t vecs[NVEC];

  tone_gen dut (
    .clk_144      (clk_144),
    .reset        (reset),
    .enable       (enable),
    .tone         (tone),
    .atten        (atten),
    .sample_valid (sample_valid),
    .toneOut      (toneOut)
  );

  always #5 clk_144 = ~clk_144;

  task automatic tick();
    @(posedge clk_144);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic edge_quiet(input string name);
    tick();
    check({name, " valid"}, int'(sample_valid), 0);
    check({name, " hold"}, int'(toneOut), int'(held));
  endtask

  task automatic edge_strobe(input string name);
    logic signed [15:0] e;
    tick();
    check({name, " valid"}, int'(sample_valid), 1);
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: got strobe with empty expected queue", name);
    end else begin
      e = exp_q.pop_front();
      check({name, " out"}, int'(toneOut), int'(e));
      held = e;
    end
  endtask

  task automatic one_sample(input string name, input logic signed [15:0] e);
    exp_q.push_back(e);
    edge_quiet(name);
    edge_quiet(name);
    edge_strobe(name);
  endtask

  initial begin
    vecs[0]  = '{2'd0, 3'd0,  16'sd0};
    vecs[1]  = '{2'd0, 3'd0,  16'sd4277};
    vecs[2]  = '{2'd0, 3'd0,  16'sd8481};
    vecs[3]  = '{2'd1, 3'd0,  16'sd12539};
    vecs[4]  = '{2'd1, 3'd0,  16'sd23170};
    vecs[5]  = '{2'd1, 3'd0,  16'sd30273};
    vecs[6]  = '{2'd0, 3'd2,  16'sd8191};
    vecs[7]  = '{2'd3, 3'd0,  16'sd0};
    vecs[8]  = '{2'd3, 3'd0,  16'sd0};
    vecs[9]  = '{2'd0, 3'd0,  16'sd32487};
    vecs[10] = '{2'd2, 3'd0,  16'sd31650};
    vecs[11] = '{2'd2, 3'd0, -16'sd23170};
    vecs[12] = '{2'd2, 3'd0, -16'sd8481};
    vecs[13] = '{2'd2, 3'd1,  16'sd15825};
    vecs[14] = '{2'd1, 3'd0, -16'sd23170};
    vecs[15] = '{2'd0, 3'd7, -16'sd237};
    vecs[16] = '{2'd0, 3'd3, -16'sd3957};
    vecs[17] = '{2'd0, 3'd7, -16'sd254};
    vecs[18] = '{2'd0, 3'd7, -16'sd256};
    vecs[19] = '{2'd0, 3'd0, -16'sd32487};
    vecs[20] = '{2'd1, 3'd4, -16'sd1979};
    vecs[21] = '{2'd1, 3'd0, -16'sd25996};
    vecs[22] = '{2'd1, 3'd0, -16'sd16384};
    vecs[23] = '{2'd1, 3'd0, -16'sd4277};
    vecs[24] = '{2'd0, 3'd0,  16'sd8481};

    reset  = 1'b1;
    enable = 1'b1;
    tone   = 2'd0;
    atten  = 3'd0;
    held   = 16'sd0;
    tick();
    tick();
    check("reset valid", int'(sample_valid), 0);
    check("reset out", int'(toneOut), 0);
    reset = 1'b0;

    // First vector also checks the strobe lands on the 3rd edge after release.
    for (int i = 0; i < NVEC; i++) begin
      tone  = vecs[i].tone;
      atten = vecs[i].atten;
      one_sample($sformatf("vec%0d", i), vecs[i].exp_out);
    end

    // Freeze with div=1, then resume: strobe arrives 2 edges later.
    tone  = 2'd0;
    atten = 3'd0;
    edge_quiet("pre_freeze");
    enable = 1'b0;
    for (int i = 0; i < 5; i++) edge_quiet($sformatf("freeze%0d", i));
    enable = 1'b1;
    exp_q.push_back(16'sd12539);
    edge_quiet("resume");
    edge_strobe("resume");

    // Reset landing at div=2 swallows the pending strobe.
    edge_quiet("pre_rst");
    edge_quiet("pre_rst");
    reset = 1'b1;
    held  = 16'sd0;
    edge_quiet("mid_rst");
    reset = 1'b0;
    one_sample("post_rst", 16'sd0);

    // 16 kHz from phase 0, then 1 kHz taking over at phase 32.
    reset = 1'b1;
    held  = 16'sd0;
    edge_quiet("rst2");
    reset = 1'b0;
    tone  = 2'd2;
    one_sample("k16_a", 16'sd0);
    one_sample("k16_b", 16'sd28377);
    tone = 2'd0;
    one_sample("k1_ph32", -16'sd28377);
    one_sample("k1_ph33", -16'sd30273);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tone_gen.md
TONE_GEN -- requirements
Module: tone_gen

Interface
REQ-001 Clocking and reset: one clock; reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_SAMPLE, default 3; clk_144 cycles per 48 kHz audio sample.
REQ-003 Parameter SAMPLES_PER_CYCLE, default 48; phase table length for one full sine period.
REQ-004 clk_144  in  1  system clock, 144 kHz.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 enable  in  1  run generator; low freezes all state.
REQ-007 tone  in  2  frequency select: 0=1 kHz, 1=3 kHz, 2=16 kHz, 3=mute.
REQ-008 atten  in  3  attenuation, arithmetic right shift of 0..7 bits.
REQ-009 sample_valid  out  1  one-cycle strobe marking a new toneOut sample.
REQ-010 toneOut  out  16 signed  audio sample for the filter stage, e.g. highpassIn.

Function
REQ-011 Divider div (0..CLKS_PER_SAMPLE-1) SHALL increment on each enabled edge and wrap to 0 after reaching 2.
REQ-012 On an enabled edge with div==2: toneOut <= sine(phase) >>> atten; phase <= (phase+step) mod 48; sample_valid <= 1.
REQ-013 On all other edges sample_valid SHALL be 0, and toneOut SHALL hold its value.
REQ-014 Step SHALL be 1 for tone 0, 3 for tone 1 and 16 for tone 2, giving 48, 16 and 3 samples per period.
REQ-015 Phase SHALL wrap modulo 48 with no skipped index (e.g. 45+3 gives 0, 32+16 gives 0).
REQ-016 sine(k) SHALL come from a 13-entry quarter-wave table T: 0, 4277, 8481, 12539, 16384, 19947, 23170, 25996, 28377, 30273, 31650, 32487, 32767.
REQ-017 Quarter reconstruction, with q=k/12 and r=k%12: q0 gives T[r]; q1 gives T[12-r]; q2 gives -T[r]; q3 gives -T[12-r].
REQ-018 Tone 3 (mute): toneOut SHALL be 0 at each strobe, phase SHALL hold, and sample_valid SHALL still pulse.
REQ-019 A change on tone or atten SHALL take effect only at the next strobe; phase SHALL continue and SHALL NOT reset.
REQ-020 enable low SHALL hold div, phase and toneOut and force sample_valid to 0; resuming SHALL continue from the held div value.
REQ-021 Sample latency: the first strobe after reset release, with enable high, SHALL occur on the 3rd rising edge, with toneOut=0.
REQ-022 The shift SHALL be arithmetic: negative values stay negative, and -32767>>>7 gives -256.
REQ-023 No intermediate result SHALL exceed 16 bits signed; no saturation logic is required.

Reset
REQ-024 While reset is high at an edge: div=0, phase=0, toneOut=0, sample_valid=0.
REQ-025 Reset SHALL take priority over enable, including when asserted mid-sample (div=1 or 2).
REQ-026 Reset asserted mid-sample SHALL suppress the pending strobe.

Structure
REQ-027 Shared package tone_pkg SHALL hold:
- the tone_e enum (TONE_1K, TONE_3K, TONE_16K, TONE_MUTE);
- the CLKS_PER_SAMPLE and SAMPLES_PER_CYCLE constants;
- the quarter-wave table T;
- the step-per-tone function.
REQ-028 One combinational sub-module, sine_lut, SHALL map a 6-bit phase to a 16-bit signed sample per REQ-016/017.
REQ-029 tone_gen SHALL contain only the divider, the phase accumulator and the output registers; all outputs SHALL be registered.

Verification
REQ-030 1 kHz, atten 0, 48 strobes: sequence 0, 4277, 8481, ..., 32767 (index 12), ..., -32767 (index 36), ..., -4277; then repeats.
REQ-031 3 kHz: strobes 0, 12539, 23170, 30273, 32767, 30273, ...; period is 16 strobes.
REQ-032 16 kHz: 0, 28377, -28377 repeating; switching to 1 kHz at phase 32 next yields index 33 value -30273.
REQ-033 atten=2 at 1 kHz index 12: 8191; atten=7 at index 36: -256; mute: toneOut 0, and resuming 1 kHz continues from the held phase.
REQ-034 Strobe spacing: exactly one sample_valid per 3 edges; enable low for 5 cycles gives no strobes and frozen outputs, and timing resumes from the held div.
REQ-035 Reset at div=2: no strobe that cycle, outputs 0, and the first strobe lands 3 edges after release.
